// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit blocks.
//   - uart_state_t : receiver frame-state encoding
//   - DEF_*        : default frame/baud settings (12 MHz clock, 9600 baud, 8N2, 16-bit words)
//   - width helpers: baud counter width, bytes per word, byte index width,
//                    evaluated by the instantiating module from its own parameters
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_t;

  localparam int unsigned DEF_BAUD_2_CLOCK_RATIO = 1250;
  localparam int unsigned DEF_UART_DATA_BITS     = 8;
  localparam int unsigned DEF_UART_STOP_BITS     = 2;
  localparam int unsigned DEF_OUTPUT_DATA_WIDTH  = 16;
  localparam int unsigned DEF_TIMEOUT_BITS       = 20;

  // Bits needed to count 0..ratio-1.
  function automatic int unsigned baud_cnt_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned word_width,
                                                 input int unsigned data_bits);
    return word_width / data_bits;
  endfunction

  // A one-lane word still gets a 1-bit index so the port/reg is never zero width.
  function automatic int unsigned byte_idx_width(input int unsigned num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so a line that idles high never produces a false
// falling edge when reset is released.
//   clk  : destination clock
//   rst  : asynchronous reset, active-high
//   d    : asynchronous input
//   q    : synchronized output (2-cycle latency)
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Samples rx at mid-bit, checks stop bits, assembles
// OUTPUT_DATA_WIDTH/UART_DATA_BITS bytes (LSB byte first) into one word and
// offers it on a valid/ready handshake.
//   clk        : system clock
//   rst        : asynchronous reset, active-high
//   rx         : serial input, idle high, asynchronous to clk
//   data_out   : assembled word, stable while data_valid=1
//   data_valid : word available, held until accepted
//   data_ready : consumer accepts when data_valid & data_ready
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overrun    : one-cycle pulse when a word completes while the previous one is unaccepted
// Optional build macro UART_RX_TIMEOUT_EN: discard a partial word when the line
// stays idle longer than TIMEOUT_BITS bit periods between bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_2_CLOCK_RATIO = DEF_BAUD_2_CLOCK_RATIO,
  parameter int unsigned UART_DATA_BITS     = DEF_UART_DATA_BITS,
  parameter int unsigned UART_STOP_BITS     = DEF_UART_STOP_BITS,
  parameter int unsigned OUTPUT_DATA_WIDTH  = DEF_OUTPUT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_BITS       = DEF_TIMEOUT_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic                         frame_err,
  output logic                         overrun
);

  localparam int unsigned CNT_W     = baud_cnt_width(BAUD_2_CLOCK_RATIO);
  localparam int unsigned NUM_BYTES = bytes_per_word(OUTPUT_DATA_WIDTH, UART_DATA_BITS);
  localparam int unsigned IDX_W     = byte_idx_width(NUM_BYTES);

  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(BAUD_2_CLOCK_RATIO / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BAUD_2_CLOCK_RATIO - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(UART_STOP_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);

  // Elaboration-time guard on the supported parameter ranges.
  if (BAUD_2_CLOCK_RATIO < 4 || UART_DATA_BITS < 5 || UART_DATA_BITS > 8 ||
      UART_STOP_BITS < 1 || UART_STOP_BITS > 2 || TIMEOUT_BITS < 1 ||
      (OUTPUT_DATA_WIDTH % UART_DATA_BITS) != 0 ||
      OUTPUT_DATA_WIDTH < UART_DATA_BITS) begin : g_param_check
    $error("uart_rx: parameter out of supported range");
  end

  uart_state_t                   state_r;
  logic [CNT_W-1:0]              cnt_r;
  logic [2:0]                    bit_cnt_r;
  logic                          stop_cnt_r;
  logic                          stop_ok_r;
  logic [UART_DATA_BITS-1:0]     shift_r;
  logic [OUTPUT_DATA_WIDTH-1:0]  word_r;
  logic [IDX_W-1:0]              idx_r;

  logic                          rx_sync_s;
  logic                          stop_good_s;
  logic                          stop_last_s;
  logic                          word_done_s;
  logic                          timeout_s;
  logic [OUTPUT_DATA_WIDTH-1:0]  full_word_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_sync_s)
  );

  // Word as it will look once the byte just received is placed in its lane,
  // and detection of the last good stop sample of the last lane.
  always_comb begin
    full_word_s = word_r;
    full_word_s[int'(idx_r) * UART_DATA_BITS +: UART_DATA_BITS] = shift_r;
    stop_good_s = stop_ok_r & rx_sync_s;
    stop_last_s = (state_r == STOP) && (cnt_r == LAST_CNT) && (stop_cnt_r == LAST_STOP);
    word_done_s = stop_last_s && stop_good_s && (idx_r == LAST_IDX);
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * BAUD_2_CLOCK_RATIO;
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 2);

  logic [GAP_W-1:0] gap_r;

  // Inter-byte idle gap, counted only while a partial word is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_r <= {GAP_W{1'b0}};
    end else if ((state_r == IDLE) && (idx_r != {IDX_W{1'b0}}) && !timeout_s) begin
      gap_r <= gap_r + GAP_W'(1);
    end else begin
      gap_r <= {GAP_W{1'b0}};
    end
  end

  assign timeout_s = (gap_r > GAP_W'(GAP_LIMIT));
`else
  assign timeout_s = 1'b0;
`endif

  // Frame FSM, byte assembly and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      stop_ok_r  <= 1'b0;
      shift_r    <= {UART_DATA_BITS{1'b0}};
      word_r     <= {OUTPUT_DATA_WIDTH{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      data_out   <= {OUTPUT_DATA_WIDTH{1'b0}};
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A completing word may replace one being accepted this very cycle.
      if (word_done_s) begin
        if (!data_valid || data_ready) begin
          data_out   <= full_word_s;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (timeout_s) begin
            idx_r <= {IDX_W{1'b0}};
          end
          if (!rx_sync_s) begin
            state_r <= START;
          end
        end

        START: begin
          if (cnt_r == HALF_CNT) begin
            cnt_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= 3'd0;
            // Line back high at mid start bit: a glitch, not a frame.
            state_r   <= rx_sync_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {rx_sync_s, shift_r[UART_DATA_BITS-1:1]};
            if (bit_cnt_r == LAST_BIT) begin
              state_r    <= STOP;
              stop_cnt_r <= 1'b0;
              stop_ok_r  <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r     <= {CNT_W{1'b0}};
            stop_ok_r <= stop_good_s;
            if (stop_cnt_r == LAST_STOP) begin
              if (stop_good_s) begin
                word_r[int'(idx_r) * UART_DATA_BITS +: UART_DATA_BITS] <= shift_r;
                idx_r   <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
                state_r <= IDLE;
              end else begin
                frame_err <= 1'b1;
                idx_r     <= {IDX_W{1'b0}};
                state_r   <= WAIT_HIGH;
              end
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        WAIT_HIGH: begin
          if (rx_sync_s) begin
            state_r <= IDLE;
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
